// File: rtl/way_rr_arbiter.sv
// Round-robin arbiter over NUMBER_WAYS requesters with burst lock, feeding a
// single-entry output register whose one-hot grant drives the way-mux select.
module way_rr_arbiter #(
  parameter int NUMBER_WAYS                 = 8,
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 4
) (
  input  logic                                               clk_in,
  input  logic                                               reset_in,
  input  logic [NUMBER_WAYS-1:0]                             request_valid_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0] request_packed_in,
  input  logic [NUMBER_WAYS-1:0]                             request_lock_in,
  output logic [NUMBER_WAYS-1:0]                             request_ack_out,
  output logic [NUMBER_WAYS-1:0]                             grant_out,
  output logic                                               issue_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             issue_packed_out,
  input  logic                                               issue_ack_in
);

  localparam int W     = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int PTR_W = (NUMBER_WAYS > 1) ? $clog2(NUMBER_WAYS) : 1;
  localparam logic [NUMBER_WAYS-1:0] ONE_HOT_0 = {{(NUMBER_WAYS-1){1'b0}}, 1'b1};

  typedef enum logic {ST_ARB, ST_LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [W-1:0]           issue_packed_q, issue_packed_d;
  logic [NUMBER_WAYS-1:0] grant_q, grant_d;

  logic [NUMBER_WAYS-1:0] candidates;
  logic [PTR_W-1:0]       winner;
  logic                   winner_found;
  logic                   can_accept;
  logic                   accept;
  logic [NUMBER_WAYS-1:0] winner_one_hot;
  int                     idx;

  // Rotating priority search starting just after the last winner.
  // NOTE: always_comb uses blocking '=' with a default for every target so no
  // latch is inferred; state is only ever updated with '<=' in always_ff.
  always_comb begin
    candidates   = (state_q == ST_LOCKED) ? (request_valid_in & (ONE_HOT_0 << owner_q))
                                          : request_valid_in;
    winner       = '0;
    winner_found = 1'b0;
    idx          = 0;
    for (int k = 1; k <= NUMBER_WAYS; k++) begin
      idx = (int'(ptr_q) + k) % NUMBER_WAYS;
      if (!winner_found && candidates[PTR_W'(idx)]) begin
        winner_found = 1'b1;
        winner       = PTR_W'(idx);
      end
    end
  end

  assign can_accept      = !issue_valid_q || issue_ack_in;
  assign accept          = can_accept && winner_found && !reset_in;
  assign winner_one_hot  = ONE_HOT_0 << winner;
  assign request_ack_out = accept ? winner_one_hot : '0;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    issue_valid_d  = issue_valid_q;
    issue_packed_d = issue_packed_q;
    grant_d        = grant_q;
    if (accept) begin
      issue_valid_d  = 1'b1;
      issue_packed_d = request_packed_in[winner*W +: W];
      grant_d        = winner_one_hot;
      ptr_d          = winner;
      if (state_q == ST_ARB && request_lock_in[winner]) begin
        state_d = ST_LOCKED;
        owner_d = winner;
      end else if (state_q == ST_LOCKED && !request_lock_in[winner]) begin
        state_d = ST_ARB;
      end
    end else if (issue_ack_in) begin
      issue_valid_d = 1'b0;
      grant_d       = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q        <= ST_ARB;
      ptr_q          <= PTR_W'(NUMBER_WAYS - 1);
      owner_q        <= '0;
      issue_valid_q  <= 1'b0;
      issue_packed_q <= '0;
      grant_q        <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      issue_valid_q  <= issue_valid_d;
      issue_packed_q <= issue_packed_d;
      grant_q        <= grant_d;
    end
  end

  assign grant_out        = grant_q;
  assign issue_valid_out  = issue_valid_q;
  assign issue_packed_out = issue_packed_q;

endmodule

// File: tb/tb_way_rr_arbiter.sv
// Directed bench for way_rr_arbiter: a rotating-priority reference model checked
// on every falling edge, plus hand-computed expectations at key cycles.
module tb_way_rr_arbiter;
  localparam int N = 8;
  localparam int W = 4;

  logic           clk_in = 1'b0;
  logic           reset_in = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N*W-1:0] req_packed = '0;
  logic           issue_ack_in = 1'b0;
  logic [N-1:0]   request_ack_out;
  logic [N-1:0]   grant_out;
  logic           issue_valid_out;
  logic [W-1:0]   issue_packed_out;

  int n_vec = 0;
  int n_bad = 0;

  way_rr_arbiter #(.NUMBER_WAYS(N), .SINGLE_ELEMENT_SIZE_IN_BITS(W)) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .request_valid_in  (req_valid),
    .request_packed_in (req_packed),
    .request_lock_in   (req_lock),
    .request_ack_out   (request_ack_out),
    .grant_out         (grant_out),
    .issue_valid_out   (issue_valid_out),
    .issue_packed_out  (issue_packed_out),
    .issue_ack_in      (issue_ack_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: rotating pointer, optional lock owner, one held beat.
  int           m_ptr    = N - 1;
  bit           m_locked = 1'b0;
  int           m_owner  = 0;
  bit           m_valid  = 1'b0;
  logic [W-1:0] m_pay    = '0;
  logic [N-1:0] m_grant  = '0;

  always @(negedge clk_in) begin : compare
    int           win;
    bit           can;
    logic [N-1:0] exp_ack;
    if (reset_in) begin
      check("reset_valid", issue_valid_out, 0);
      check("reset_grant", grant_out, 0);
      check("reset_ack", request_ack_out, 0);
      m_ptr = N - 1; m_locked = 0; m_owner = 0;
      m_valid = 0; m_pay = '0; m_grant = '0;
    end else begin
      check("model_valid", issue_valid_out, m_valid);
      check("model_grant", grant_out, m_grant);
      check("model_payload", issue_packed_out, m_pay);
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (win < 0 && req_valid[i] && (!m_locked || i == m_owner)) win = i;
      end
      can = !m_valid || issue_ack_in;
      exp_ack = '0;
      if (can && win >= 0) exp_ack[win] = 1'b1;
      check("model_ack", request_ack_out, exp_ack);
      if (can && win >= 0) begin
        m_valid = 1'b1;
        m_pay   = req_packed[win*W +: W];
        m_grant = exp_ack;
        m_ptr   = win;
        if (!m_locked && req_lock[win]) begin
          m_locked = 1'b1;
          m_owner  = win;
        end else if (m_locked && !req_lock[win]) begin
          m_locked = 1'b0;
        end
      end else if (issue_ack_in) begin
        m_valid = 1'b0;
        m_grant = '0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
    #1;
  endtask

  task automatic ack_is(input string name, input logic [N-1:0] exp);
    mid();
    check(name, request_ack_out, exp);
  endtask

  task automatic outs_are(input string name, input logic v, input logic [N-1:0] g, input logic [W-1:0] p);
    check({name, "_valid"}, issue_valid_out, v);
    check({name, "_grant"}, grant_out, g);
    check({name, "_payload"}, issue_packed_out, p);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int i = 0; i < N; i++) req_packed[i*W +: W] = W'(i + 1);

    // Reset: ack must stay low even with every requester valid.
    reset_in = 1'b1; req_valid = 8'hFF; issue_ack_in = 1'b1;
    repeat (2) cyc();
    ack_is("rst_ack", 8'h00); outs_are("rst", 0, 8'h00, 4'h0); cyc();
    reset_in = 1'b0; req_valid = 8'b1000_0101;

    // Rotation among 0, 2, 7 with continuous drain.
    ack_is("rr0", 8'h01); cyc();
    ack_is("rr1", 8'h04); outs_are("rr1", 1, 8'h01, 4'h1); cyc();
    ack_is("rr2", 8'h80); outs_are("rr2", 1, 8'h04, 4'h3); cyc();
    ack_is("rr3", 8'h01); outs_are("rr3", 1, 8'h80, 4'h8); cyc();
    ack_is("rr4", 8'h04); outs_are("rr4", 1, 8'h01, 4'h1); cyc();

    // Idle with drain: outputs empty, pointer stays at 2.
    req_valid = 8'h00;
    ack_is("idle0", 8'h00); outs_are("idle0", 1, 8'h04, 4'h3); cyc();
    ack_is("idle1", 8'h00); check("idle1_valid", issue_valid_out, 0); check("idle1_grant", grant_out, 0); cyc();
    req_valid = 8'hFF;
    ack_is("idle_resume", 8'h08); cyc();
    req_valid = 8'h00;
    mid(); cyc();

    // Back-pressure on requester 3 carrying 4'hA.
    req_packed[3*W +: W] = 4'hA;
    req_valid = 8'h08; issue_ack_in = 1'b0;
    ack_is("bp_first", 8'h08); cyc();
    for (int c = 0; c < 5; c++) begin
      ack_is("bp_hold", 8'h00); outs_are("bp_hold", 1, 8'h08, 4'hA); cyc();
    end
    issue_ack_in = 1'b1;
    ack_is("bp_second", 8'h08); cyc();
    req_valid = 8'h00;
    mid(); cyc();

    // Park pointer at 7 so requester 1 wins before 5.
    req_valid = 8'h80;
    ack_is("lock_pre", 8'h80); cyc();
    req_valid = 8'h22; req_lock = 8'h02;
    ack_is("lock_b0", 8'h02); cyc();
    ack_is("lock_b1", 8'h02); outs_are("lock_b1", 1, 8'h02, 4'h2); cyc();
    req_lock = 8'h00;
    ack_is("lock_b2", 8'h02); cyc();
    ack_is("lock_after", 8'h20); check("lock_after_grant", grant_out, 8'h02); cyc();
    req_valid = 8'h00;
    mid(); cyc();

    // Locked owner 4 goes quiet while requester 6 waits.
    req_valid = 8'h10; req_lock = 8'h10;
    ack_is("gap_lock", 8'h10); cyc();
    req_valid = 8'h40; req_lock = 8'h00;
    ack_is("gap0", 8'h00); outs_are("gap0", 1, 8'h10, 4'h5); cyc();
    ack_is("gap1", 8'h00); check("gap1_valid", issue_valid_out, 0); check("gap1_grant", grant_out, 0); cyc();
    req_valid = 8'h50;
    ack_is("gap_owner", 8'h10); cyc();
    ack_is("gap_other", 8'h40); check("gap_other_grant", grant_out, 8'h10); cyc();
    req_valid = 8'h00;
    mid(); cyc();

    // Asynchronous reset while locked with a held beat.
    issue_ack_in = 1'b0; req_valid = 8'h04; req_lock = 8'h04;
    ack_is("rm_lock", 8'h04); cyc();
    ack_is("rm_held", 8'h00); outs_are("rm_held", 1, 8'h04, 4'h3); cyc();
    reset_in = 1'b1;
    #1;
    check("rm_async_valid", issue_valid_out, 0);
    check("rm_async_grant", grant_out, 0);
    check("rm_async_ack", request_ack_out, 0);
    mid(); cyc();
    reset_in = 1'b0; req_valid = 8'hFF; req_lock = 8'h00; issue_ack_in = 1'b1;
    ack_is("rm_first", 8'h01); cyc();
    ack_is("rm_second", 8'h02); outs_are("rm_second", 1, 8'h01, 4'h1); cyc();

    // Idle again, then rotation continues from requester 1.
    req_valid = 8'h00;
    mid(); cyc();
    for (int c = 0; c < 3; c++) begin
      ack_is("idle_end", 8'h00); check("idle_end_valid", issue_valid_out, 0); check("idle_end_grant", grant_out, 0); cyc();
    end
    req_valid = 8'hFF;
    ack_is("idle_end_resume", 8'h04); cyc();
    req_valid = 8'h00;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/way_rr_arbiter.md
# way_rr_arbiter

Round-robin arbiter that shares one W-bit datapath between NUMBER_WAYS requesters and drives the one-hot select of the decoded way mux. Each cycle it picks at most one valid requester, acknowledges it, and captures its payload into a single-entry output register with a valid/ack handshake toward the consumer. Requesters may lock the arbiter for multi-beat bursts. It sits between the per-way request sources and the shared issue path, and its registered one-hot grant feeds the downstream mux select directly.

## Interface
- NUMBER_WAYS, 8, number of requesters; one-hot width of grant
- SINGLE_ELEMENT_SIZE_IN_BITS, 4, payload width W per requester

- clk_in  in  1  clock, all state on rising edge
- reset_in  in  1  asynchronous, active-high reset
- request_valid_in  in  NUMBER_WAYS  per-requester request valid
- request_packed_in  in  W*NUMBER_WAYS  payloads; requester i at bits [(i+1)*W-1 : i*W]
- request_lock_in  in  NUMBER_WAYS  per-requester "more beats follow" (burst lock)
- request_ack_out  out  NUMBER_WAYS  one-hot, combinational; high in the cycle requester i's beat is accepted
- grant_out  out  NUMBER_WAYS  registered one-hot owner of the beat in the output register; zero when empty
- issue_valid_out  out  1  output register holds a beat
- issue_packed_out  out  W  payload of held beat
- issue_ack_in  in  1  consumer takes held beat this cycle (meaningful only with issue_valid_out)

## Operation
- Reset: issue_valid_out=0, issue_packed_out=0, grant_out=0, round-robin pointer=NUMBER_WAYS-1 (so requester 0 has top priority first), state=ARB, lock owner=0. request_ack_out is 0 while reset_in high.
- can_accept = !issue_valid_out | issue_ack_in.
- ARB state: candidate set = request_valid_in. Winner = first set bit searching i = ptr+1, ptr+2, ... modulo NUMBER_WAYS. If can_accept and any candidate: request_ack_out[winner]=1; at the edge the output register loads winner's payload, grant_out=one-hot(winner), issue_valid_out=1, ptr=winner. If request_lock_in[winner]=1, go to LOCKED with owner=winner.
- LOCKED state: candidate set = request_valid_in & one-hot(owner). Other requesters are never acknowledged. On each accepted owner beat with request_lock_in[owner]=0, return to ARB, ptr=owner. If the owner drops valid, no beat is accepted and the state stays LOCKED.
- No accept (can_accept=0 or empty candidate set): request_ack_out=0. If issue_ack_in, clear issue_valid_out and grant_out to 0. Otherwise hold the register.
- Payload, grant and valid hold stable while issue_valid_out=1 and issue_ack_in=0.
- request_lock_in is sampled only on the accepted beat.
- Non-one-hot request sets are normal. Only the winner is acknowledged; losers keep valid and retry.

## Timing
- Latency: beat accepted (ack) in cycle N -> issue_valid_out/issue_packed_out/grant_out in cycle N+1.
- Throughput: one beat per cycle when issue_ack_in is held high (simultaneous drain and load in the same cycle).
- request_ack_out depends combinationally on request_valid_in, issue_valid_out, issue_ack_in and state. There is no combinational path from request inputs to issue_*/grant_out.
- Asynchronous reset mid-burst drops the held beat and the lock immediately. The first post-reset winner is the lowest-index valid requester.

## Test plan
- Reset then request_valid_in=8'b1000_0101, issue_ack_in=1 constant -> acks 0,2,7,0,2,7…, grant_out one cycle later 8'h01,8'h04,8'h80,…; payload matches slice.
- Back-pressure: single requester 3, payload 4'hA, issue_ack_in=0 for 5 cycles -> one ack, issue_valid_out=1, issue_packed_out=A, grant_out=8'h08 stable. The second beat is acked only in the cycle issue_ack_in=1.
- Lock: requester 1 sends 3 beats with lock=1,1,0 while requester 5 is valid throughout, issue_ack_in=1 -> acks 1,1,1 then 5. Requester 5 is never acked during the burst.
- Locked owner gap: owner 4 locked, drops valid 2 cycles while requester 6 is valid -> no acks, issue_valid_out falls to 0 and grant_out=0. Owner returns and is acked first.
- Reset mid-burst: assert reset_in while locked with beat held -> issue_valid_out=0, grant_out=0 in the same cycle. After release, valid 8'hFF -> ack 0 first.
- Idle: no requests, issue_ack_in=1 -> all outputs 0, pointer unchanged (next grant continues rotation).
